// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO and sequences fixed-latency
// mult (5 cycles) and div (10 cycles) operations for the E stage.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        check_D,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  // Results are computed only from the operands captured at launch.
  always_comb begin
    a_ext  = {{32{a_q[31]}}, a_q};
    b_ext  = {{32{b_q[31]}}, b_q};
    prod_s = a_ext * b_ext;
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    a_s    = a_q;
    b_s    = b_q;
    quo_s  = '0;
    rem_s  = '0;
    quo_u  = '0;
    rem_u  = '0;
    if (b_q != '0) begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (MDUOp == OP_MULT || MDUOp == OP_MULTU)) begin
            state <= MULT;
            cnt   <= 4'd5;
            op_q  <= MDUOp;
            a_q   <= A;
            b_q   <= B;
          end else if (start && (MDUOp == OP_DIV || MDUOp == OP_DIVU)) begin
            state <= DIV;
            cnt   <= 4'd10;
            op_q  <= MDUOp;
            a_q   <= A;
            b_q   <= B;
          end else if (!start && MDUOp == OP_MTHI) begin
            HI <= A;
          end else if (!start && MDUOp == OP_MTLO) begin
            LO <= A;
          end
        end
        MULT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (op_q == OP_MULT) {HI, LO} <= prod_s;
            else                 {HI, LO} <= prod_u;
          end
        end
        DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            // Divide by zero still burns the full latency but leaves HI/LO intact.
            if (b_q != '0) begin
              if (op_q == OP_DIV) begin
                HI <= rem_s;
                LO <= quo_s;
              end else begin
                HI <= rem_u;
                LO <= quo_u;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = check_D & (start | busy);

  always_comb begin
    MDUout = '0;
    if (MDUOp == OP_MFHI)      MDUout = HI;
    else if (MDUOp == OP_MFLO) MDUout = LO;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pairs are queued at launch and
// checked when busy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        check_D;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUout;
  logic        busy;
  logic        stall;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
    .check_D(check_D), .HI(HI), .LO(LO), .MDUout(MDUout), .busy(busy),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: signed ops derived from unsigned arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    case (op)
      4'd1: begin
        p = {32'b0, a} * {32'b0, b};
        if (a[31]) p = p - {b, 32'b0};
        if (b[31]) p = p - {a, 32'b0};
        return p;
      end
      4'd2: return {32'b0, a} * {32'b0, b};
      4'd3: begin
        if (b == '0) return prev;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      4'd4: begin
        if (b == '0) return prev;
        return {a % b, a / b};
      end
      default: return prev;
    endcase
  endfunction

  task automatic launch(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
    logic [63:0] e;
    start = 1'b1; MDUOp = op; A = a; B = b;
    #1;
    chk("stall_launch", {63'b0, stall}, {63'b0, check_D});
    if (push) begin
      e = model(op, a, b, {hi_m, lo_m});
      sb.push_back(e);
      {hi_m, lo_m} = e;
    end
    tick();
    start = 1'b0; MDUOp = 4'd0;
    A = ~a; B = ~b;
  endtask

  task automatic wait_done(input string tag, input int unsigned exp_n);
    int unsigned n = 0;
    logic [63:0] e;
    while (busy && n < 30) begin
      chk("stall_busy", {63'b0, stall}, {63'b0, check_D});
      n++;
      tick();
    end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_stall_after"}, {63'b0, stall}, 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, {32'b0, HI}, {32'b0, e[63:32]});
      chk({tag, "_lo"}, {32'b0, LO}, {32'b0, e[31:0]});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = '0; B = '0; check_D = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_hi", {32'b0, HI}, 64'd0);
    chk("rst_lo", {32'b0, LO}, 64'd0);
    chk("rst_mdout", {32'b0, MDUout}, 64'd0);

    check_D = 1'b1;
    launch(4'd1, 32'd3, 32'hFFFF_FFFE, 1'b1);
    wait_done("mult", 5);
    chk("mult_hi_k", {32'b0, HI}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo_k", {32'b0, LO}, 64'h0000_0000_FFFF_FFFA);

    check_D = 1'b0;
    launch(4'd2, 32'd3, 32'hFFFF_FFFE, 1'b1);
    wait_done("multu", 5);
    chk("multu_hi_k", {32'b0, HI}, 64'h2);
    chk("multu_lo_k", {32'b0, LO}, 64'hFFFF_FFFA);

    launch(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div", 10);
    chk("div_lo_k", {32'b0, LO}, 64'hFFFF_FFFD);
    chk("div_hi_k", {32'b0, HI}, 64'hFFFF_FFFF);

    launch(4'd4, 32'd7, 32'd2, 1'b1);
    wait_done("divu", 10);
    chk("divu_lo_k", {32'b0, LO}, 64'd3);
    chk("divu_hi_k", {32'b0, HI}, 64'd1);

    MDUOp = 4'd7; A = 32'h11; tick();
    MDUOp = 4'd8; A = 32'h22; tick();
    MDUOp = 4'd0;
    hi_m = 32'h11; lo_m = 32'h22;
    chk("mthi", {32'b0, HI}, 64'h11);
    chk("mtlo", {32'b0, LO}, 64'h22);

    launch(4'd4, 32'd5, 32'd0, 1'b1);
    wait_done("div0", 10);
    chk("div0_hi_k", {32'b0, HI}, 64'h11);
    chk("div0_lo_k", {32'b0, LO}, 64'h22);

    // start together with an mt encoding: no launch and no write
    start = 1'b1; MDUOp = 4'd7; A = 32'h99; tick();
    start = 1'b0; MDUOp = 4'd0;
    chk("start_mt_busy", {63'b0, busy}, 64'd0);
    chk("start_mt_hi", {32'b0, HI}, {32'b0, hi_m});

    // second start in busy cycle 2 is ignored
    launch(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    tick();
    start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; MDUOp = 4'd0;
    wait_done("restart", 3);

    // mthi while busy is ignored (div by zero keeps HI from the model)
    launch(4'd4, 32'd5, 32'd0, 1'b1);
    MDUOp = 4'd7; A = 32'hDEAD;
    tick();
    MDUOp = 4'd0;
    wait_done("mt_busy", 9);

    MDUOp = 4'd5; #1;
    chk("mfhi", {32'b0, MDUout}, {32'b0, hi_m});
    MDUOp = 4'd6; #1;
    chk("mflo", {32'b0, MDUout}, {32'b0, lo_m});
    MDUOp = 4'd9; #1;
    chk("mf_none", {32'b0, MDUout}, 64'd0);
    MDUOp = 4'd0;

    for (int i = 0; i < 8; i++) begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      op = 4'($urandom_range(1, 4));
      ra = $urandom();
      rb = (i == 5) ? 32'd0 : $urandom();
      if (rb == 32'hFFFF_FFFF) rb = 32'd3;
      check_D = 1'($urandom_range(0, 1));
      launch(op, ra, rb, 1'b1);
      wait_done("rand", (op <= 4'd2) ? 5 : 10);
    end

    // reset during busy cycle 4 of a div aborts it with no write
    check_D = 1'b0;
    launch(4'd3, 32'd100, 32'd7, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hi", {32'b0, HI}, 64'd0);
    chk("abort_lo", {32'b0, LO}, 64'd0);
    repeat (12) tick();
    chk("abort_hi_late", {32'b0, HI}, 64'd0);
    chk("abort_lo_late", {32'b0, LO}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
